// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the system-ID boot probe.
// The state list and word addresses are used by the sequencer top.
package sysid_probe_pkg;

  localparam int SYSID_DW = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID_REQ,
    RD_ID_WAIT,
    RD_TS_REQ,
    RD_TS_WAIT,
    CHECK,
    DONE,
    ERR
  } probe_state_e;

  function automatic logic is_end(input probe_state_e s);
    return (s == DONE) || (s == ERR);
  endfunction

  function automatic logic is_idle_like(input probe_state_e s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/sysid_probe_timer.sv
// Per-attempt timeout counter for one read.
// The count is zero in the first cycle of an attempt, and expired is raised in the attempt's last allowed cycle.
module sysid_probe_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // clear has priority so a retry restarts the window on the same edge
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/sysid_probe_ctrl.sv
// Boot-time sequencer: reads the ID and timestamp words from the sysid slave, then compares them
// with the expected build values and reports pass/fail/timeout.
module sysid_probe_ctrl
  import sysid_probe_pkg::*;
#(
  parameter logic [SYSID_DW-1:0] EXP_ID         = 32'd0,
  parameter logic [SYSID_DW-1:0] EXP_TS         = 32'd1427078857,
  parameter bit                  CHECK_TS       = 1'b1,
  parameter bit                  AUTO_START     = 1'b1,
  parameter int                  TIMEOUT_CYCLES = 16,
  parameter int                  MAX_RETRY      = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  output logic                avm_address,
  output logic                avm_read,
  input  logic                avm_waitrequest,
  input  logic [SYSID_DW-1:0] avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                busy,
  output logic                done,
  output logic                done_pulse,
  output logic [SYSID_DW-1:0] id_value,
  output logic [SYSID_DW-1:0] ts_value,
  output logic                id_ok,
  output logic                ts_ok,
  output logic                timeout_err
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam int SW = $clog2(2 * MAX_RETRY + 2);
  localparam logic [SW-1:0] STALE_MAX = {SW{1'b1}};

  probe_state_e  state, next_state;
  logic [RW-1:0] retry_cnt;
  logic [SW-1:0] stale_cnt;
  logic          auto_pending;

  logic in_req, in_wait, id_phase, accept, rd_seen, capture, stale_hit;
  logic expired, timeout, retry_ok, abandon, launch, enter_req;

  sysid_probe_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (enter_req),
    .enable  (in_req || in_wait),
    .expired (expired)
  );

  // A read that timed out after being accepted still owes a reply; stale_cnt
  // counts those replies so they are dropped instead of captured.
  always_comb begin
    in_req    = (state == RD_ID_REQ) || (state == RD_TS_REQ);
    in_wait   = (state == RD_ID_WAIT) || (state == RD_TS_WAIT);
    id_phase  = (state == RD_ID_REQ) || (state == RD_ID_WAIT);
    accept    = in_req && !avm_waitrequest;
    rd_seen   = avm_readdatavalid && (in_wait || accept);
    stale_hit = rd_seen && (stale_cnt != '0);
    capture   = rd_seen && (stale_cnt == '0);
    timeout   = expired && !capture;
    retry_ok  = (retry_cnt != RETRY_LAST);
    abandon   = timeout && (in_wait || accept);
    launch    = is_idle_like(state) && (start || auto_pending);
  end

  always_comb begin
    next_state = state;
    enter_req  = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (launch) begin
          next_state = RD_ID_REQ;
          enter_req  = 1'b1;
        end
      end
      RD_ID_REQ, RD_ID_WAIT: begin
        if (capture) begin
          next_state = RD_TS_REQ;
          enter_req  = 1'b1;
        end else if (timeout) begin
          if (retry_ok) begin
            next_state = RD_ID_REQ;
            enter_req  = 1'b1;
          end else begin
            next_state = ERR;
          end
        end else if (accept) begin
          next_state = RD_ID_WAIT;
        end
      end
      RD_TS_REQ, RD_TS_WAIT: begin
        if (capture) begin
          next_state = CHECK;
        end else if (timeout) begin
          if (retry_ok) begin
            next_state = RD_TS_REQ;
            enter_req  = 1'b1;
          end else begin
            next_state = ERR;
          end
        end else if (accept) begin
          next_state = RD_TS_WAIT;
        end
      end
      CHECK:   next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      auto_pending <= AUTO_START;
      retry_cnt    <= '0;
      stale_cnt    <= '0;
      id_value     <= '0;
      ts_value     <= '0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      done_pulse   <= 1'b0;
    end else begin
      state        <= next_state;
      auto_pending <= 1'b0;
      done_pulse   <= is_end(next_state) && !is_end(state);
      if (launch) begin
        retry_cnt <= '0;
        stale_cnt <= '0;
        id_ok     <= 1'b0;
        ts_ok     <= 1'b0;
      end else begin
        if (capture) begin
          retry_cnt <= '0;
        end else if (timeout && retry_ok) begin
          retry_cnt <= retry_cnt + 1'b1;
        end
        if (abandon && !stale_hit && (stale_cnt != STALE_MAX)) begin
          stale_cnt <= stale_cnt + 1'b1;
        end else if (stale_hit && !abandon) begin
          stale_cnt <= stale_cnt - 1'b1;
        end
      end
      if (capture && id_phase) begin
        id_value <= avm_readdata;
      end
      if (capture && !id_phase) begin
        ts_value <= avm_readdata;
      end
      if (state == CHECK) begin
        id_ok <= (id_value == EXP_ID);
        ts_ok <= CHECK_TS ? (ts_value == EXP_TS) : 1'b1;
      end
    end
  end

  assign avm_read    = in_req;
  assign avm_address = ((state == RD_TS_REQ) || (state == RD_TS_WAIT)) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy        = !is_idle_like(state);
  assign done        = is_end(state);
  assign timeout_err = (state == ERR);

endmodule

// File: tb/tb_sysid_probe_ctrl.sv
// Directed bench for sysid_probe_ctrl with a small Avalon-MM slave model.
// A second instance with CHECK_TS=0 shares the same stimulus.
module tb_sysid_probe_ctrl;

  logic        clock = 1'b0;
  logic        reset_n, start;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        avm_address, avm_read, busy, done, done_pulse, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;
  logic        nc_address, nc_read, nc_busy, nc_done, nc_done_pulse, nc_id_ok, nc_ts_ok, nc_timeout_err;
  logic [31:0] nc_id_value, nc_ts_value;

  int errors = 0;
  int checks = 0;

  logic [31:0] id_word, ts_word, stale_word;
  int          stall_left, drop_reads;
  bit          mute, inject, pend;
  logic        pend_addr;

  sysid_probe_ctrl dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .done_pulse(done_pulse), .id_value(id_value),
    .ts_value(ts_value), .id_ok(id_ok), .ts_ok(ts_ok), .timeout_err(timeout_err)
  );

  sysid_probe_ctrl #(.CHECK_TS(1'b0)) dut_nc (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(nc_address), .avm_read(nc_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(nc_busy), .done(nc_done), .done_pulse(nc_done_pulse), .id_value(nc_id_value),
    .ts_value(nc_ts_value), .id_ok(nc_id_ok), .ts_ok(nc_ts_ok), .timeout_err(nc_timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Slave model: data returns one cycle after acceptance unless muted or dropped
  task automatic applyStimulus();
    avm_readdatavalid = pend;
    avm_readdata      = pend_addr ? ts_word : id_word;
    if (inject) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = stale_word;
      inject            = 1'b0;
    end
    pend            = 1'b0;
    avm_waitrequest = 1'b0;
    if (avm_read === 1'b1) begin
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else if (drop_reads > 0) begin
        drop_reads--;
      end else if (!mute) begin
        pend      = 1'b1;
        pend_addr = avm_address;
      end
    end
  endtask

  task automatic tick();
    applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (done !== 1'b1) checkOutput({tag, "_wait_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int reads;
    reset_n = 1'b0; start = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    id_word = 32'd0; ts_word = 32'd1427078857; stale_word = 32'hDEADBEEF;
    stall_left = 0; drop_reads = 0; mute = 1'b0; inject = 1'b0; pend = 1'b0; pend_addr = 1'b0;

    repeat (3) tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_read", {31'd0, avm_read}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_id_value", id_value, 32'd0);

    // auto start on the first edge after release
    reset_n = 1'b1;
    tick();
    checkOutput("auto_read", {31'd0, avm_read}, 32'd1);
    checkOutput("auto_busy", {31'd0, busy}, 32'd1);
    waitDone("auto", 20);
    checkOutput("auto_id_ok", {31'd0, id_ok}, 32'd1);
    checkOutput("auto_ts_ok", {31'd0, ts_ok}, 32'd1);

    // 1: zero-wait slave, done six edges after start is raised
    pulseStart();
    checkOutput("t1_done_clr", {31'd0, done}, 32'd0);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    checkOutput("t1_done_early", {31'd0, done}, 32'd0);
    tick();
    checkOutput("t1_done", {31'd0, done}, 32'd1);
    checkOutput("t1_pulse", {31'd0, done_pulse}, 32'd1);
    checkOutput("t1_id_ok", {31'd0, id_ok}, 32'd1);
    checkOutput("t1_ts_ok", {31'd0, ts_ok}, 32'd1);
    checkOutput("t1_tmo", {31'd0, timeout_err}, 32'd0);
    checkOutput("t1_ts_value", ts_value, 32'd1427078857);
    checkOutput("t1_busy_end", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("t1_pulse_off", {31'd0, done_pulse}, 32'd0);
    checkOutput("t1_done_hold", {31'd0, done}, 32'd1);

    // 2: wrong timestamp, with and without the timestamp check
    ts_word = 32'h55AA0000;
    pulseStart();
    waitDone("t2", 20);
    checkOutput("t2_ts_value", ts_value, 32'h55AA0000);
    checkOutput("t2_id_ok", {31'd0, id_ok}, 32'd1);
    checkOutput("t2_ts_ok", {31'd0, ts_ok}, 32'd0);
    checkOutput("t2_nc_ts_ok", {31'd0, nc_ts_ok}, 32'd1);
    checkOutput("t2_nc_id_ok", {31'd0, nc_id_ok}, 32'd1);
    ts_word = 32'd1427078857;

    // 3: five stall cycles on the ID read
    id_word = 32'h00001234;
    stall_left = 5;
    pulseStart();
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t3_read_%0d", i), {31'd0, avm_read}, 32'd1);
      checkOutput($sformatf("t3_addr_%0d", i), {31'd0, avm_address}, 32'd0);
      tick();
    end
    checkOutput("t3_read_drop", {31'd0, avm_read}, 32'd0);
    waitDone("t3", 20);
    checkOutput("t3_id_value", id_value, 32'h00001234);
    checkOutput("t3_id_ok", {31'd0, id_ok}, 32'd0);
    checkOutput("t3_ts_ok", {31'd0, ts_ok}, 32'd1);
    id_word = 32'd0;

    // 4: no data ever; three 16-cycle attempts then ERR
    mute = 1'b1;
    pulseStart();
    reads = int'(avm_read);
    for (int i = 1; i < 48; i++) begin
      tick();
      reads += int'(avm_read);
    end
    checkOutput("t4_done_early", {31'd0, done}, 32'd0);
    checkOutput("t4_busy", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("t4_done", {31'd0, done}, 32'd1);
    checkOutput("t4_tmo", {31'd0, timeout_err}, 32'd1);
    checkOutput("t4_id_ok", {31'd0, id_ok}, 32'd0);
    checkOutput("t4_ts_ok", {31'd0, ts_ok}, 32'd0);
    checkOutput("t4_pulse", {31'd0, done_pulse}, 32'd1);
    checkOutput("t4_attempts", reads, 32'd3);
    mute = 1'b0;

    // 5: first ID reply lost, its late reply lands on the retry accept cycle
    drop_reads = 1;
    pulseStart();
    repeat (16) tick();
    checkOutput("t5_retry_read", {31'd0, avm_read}, 32'd1);
    checkOutput("t5_tmo_clr", {31'd0, timeout_err}, 32'd0);
    inject = 1'b1;
    tick();
    waitDone("t5", 40);
    checkOutput("t5_id_value", id_value, 32'd0);
    checkOutput("t5_id_ok", {31'd0, id_ok}, 32'd1);
    checkOutput("t5_tmo", {31'd0, timeout_err}, 32'd0);

    // 6: reset during the timestamp wait, then auto relaunch
    id_word = 32'h000000A5;
    pulseStart();
    repeat (3) tick();
    checkOutput("t6_id_pre", id_value, 32'h000000A5);
    checkOutput("t6_addr_pre", {31'd0, avm_address}, 32'd1);
    reset_n = 1'b0;
    tick();
    checkOutput("t6_read", {31'd0, avm_read}, 32'd0);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_done", {31'd0, done}, 32'd0);
    checkOutput("t6_id_value", id_value, 32'd0);
    checkOutput("t6_pulse", {31'd0, done_pulse}, 32'd0);
    tick();
    id_word = 32'd0;
    reset_n = 1'b1;
    tick();
    checkOutput("t6_auto_read", {31'd0, avm_read}, 32'd1);
    checkOutput("t6_auto_addr", {31'd0, avm_address}, 32'd0);
    checkOutput("t6_auto_busy", {31'd0, busy}, 32'd1);
    waitDone("t6", 20);
    checkOutput("t6_id_ok", {31'd0, id_ok}, 32'd1);
    checkOutput("t6_ts_ok", {31'd0, ts_ok}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
